// File: rtl/output_port_arbiter.sv
// Purpose:      round-robin arbiter granting one of NREQ input buffers onto a router output channel.
// Latency:      a packet granted in cycle N appears on so/do_o in cycle N+1.
// Backpressure: no grant unless ri=1 and en=1; blocked requests stay pending with rr_ptr frozen.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   en         arbitration enable
//   ri         downstream ready
//   req        per-requester request
//   vc         per-requester virtual-channel bit of the held packet
//   di         packed requester data, requester i at [PACKET_WIDTH*i +: PACKET_WIDTH]
//   gnt        one-hot combinational grant (requester pops on the edge ending a gnt cycle)
//   so         registered send strobe
//   do_o       registered packet data
//   polarity   registered phase bit, toggles every cycle out of reset
//   pkt_count  registered count of forwarded packets (wraps silently)
module output_port_arbiter #(
  parameter int PACKET_WIDTH = 64,
  parameter int NREQ         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      ri,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           vc,
  input  logic [NREQ*PACKET_WIDTH-1:0] di,
  output logic [NREQ-1:0]           gnt,
  output logic                      so,
  output logic [PACKET_WIDTH-1:0]   do_o,
  output logic                      polarity,
  output logic [15:0]               pkt_count
);

  // The pointer is two bits wide, so its natural wrap implements modulo NREQ (NREQ is fixed at 4).
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic                    so_q, so_d;
  logic [PACKET_WIDTH-1:0] do_q, do_d;
  logic                    polarity_q, polarity_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            grant_vld;

  // Eligibility and rotating-priority search starting at rr_ptr.
  always_comb begin
    elig  = req & ~(vc ^ {NREQ{polarity_q}});
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset, enable and downstream ready all gate the grant, so a stalled
  // cycle never pops a requester or moves the pointer.
  assign grant_vld = reset && en && ri && found;

  always_comb begin
    gnt = '0;
    if (grant_vld) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    polarity_d  = ~polarity_q;
    so_d        = grant_vld;
    do_d        = do_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    if (grant_vld) begin
      do_d        = di[PACKET_WIDTH*int'(win) +: PACKET_WIDTH];
      rr_ptr_d    = win + 2'd1;
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      polarity_q  <= 1'b0;
      so_q        <= 1'b0;
      do_q        <= '0;
      rr_ptr_q    <= 2'd0;
      pkt_count_q <= 16'd0;
    end else begin
      polarity_q  <= polarity_d;
      so_q        <= so_d;
      do_q        <= do_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign so        = so_q;
  assign do_o      = do_q;
  assign polarity  = polarity_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

  localparam int PW   = 64;
  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic              en;
  logic              ri;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   vc;
  logic [NREQ*PW-1:0] di;
  logic [NREQ-1:0]   gnt;
  logic              so;
  logic [PW-1:0]     do_o;
  logic              polarity;
  logic [15:0]       pkt_count;

  int checks = 0;
  int errors = 0;

  output_port_arbiter #(.PACKET_WIDTH(PW), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .ri        (ri),
    .req       (req),
    .vc        (vc),
    .di        (di),
    .gnt       (gnt),
    .so        (so),
    .do_o      (do_o),
    .polarity  (polarity),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step just past it so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D3 = 64'h4444_4444_4444_4444;

  initial begin
    logic       pol;
    logic [3:0] exp_g [0:4];
    logic [63:0] exp_d [0:3];

    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    exp_d[0] = D0; exp_d[1] = D1; exp_d[2] = D2; exp_d[3] = D3;

    // Reset with eligible requests present: grant must stay low.
    reset = 1'b0; en = 1'b1; ri = 1'b1; req = 4'b1111; vc = 4'b0000;
    di = {D3, D2, D1, D0};
    tick(); tick();
    chk("rst_gnt",   64'(gnt),       64'h0);
    chk("rst_so",    64'(so),        64'h0);
    chk("rst_do",    do_o,           64'h0);
    chk("rst_pol",   64'(polarity),  64'h0);
    chk("rst_cnt",   64'(pkt_count), 64'h0);

    // Single requester, fixed vc=0: served only in polarity-0 cycles.
    reset = 1'b1; req = 4'b0001; vc = 4'b0000;
    di = {D3, D2, D1, 64'hDEAD_BEEF_DEAD_BEEF};
    #1;
    chk("single_gnt_c0", 64'(gnt), 64'h1);
    tick();
    chk("single_so_c0",  64'(so),        64'h1);
    chk("single_do_c0",  do_o,           64'hDEAD_BEEF_DEAD_BEEF);
    chk("single_cnt_c0", 64'(pkt_count), 64'h1);
    chk("single_pol_c0", 64'(polarity),  64'h1);
    chk("single_gnt_c1", 64'(gnt),       64'h0);
    tick();
    chk("single_so_c1",  64'(so),        64'h0);
    chk("single_cnt_c1", 64'(pkt_count), 64'h1);
    chk("single_gnt_c2", 64'(gnt),       64'h1);
    tick();
    chk("single_so_c2",  64'(so),        64'h1);
    chk("single_cnt_c2", 64'(pkt_count), 64'h2);
    chk("single_gnt_c3", 64'(gnt),       64'h0);
    tick();
    chk("single_cnt_c3", 64'(pkt_count), 64'h2);

    // Fresh reset, then all four requesting with vc following polarity.
    reset = 1'b0; tick(); reset = 1'b1;
    req = 4'b1111; di = {D3, D2, D1, D0};
    pol = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vc = {4{pol}};
      #1;
      chk($sformatf("rr_gnt_%0d", c), 64'(gnt), 64'(exp_g[c]));
      tick();
      pol = ~pol;
      chk($sformatf("rr_do_%0d", c), do_o, exp_d[c]);
      chk($sformatf("rr_so_%0d", c), 64'(so), 64'h1);
    end
    chk("rr_cnt4", 64'(pkt_count), 64'h4);
    vc = {4{pol}};
    #1;
    chk("rr_gnt_4", 64'(gnt), 64'(exp_g[4]));
    tick();                       // grant to 0: rr_ptr=1, count=5, polarity=1
    pol = ~pol;
    chk("rr_cnt5", 64'(pkt_count), 64'h5);

    // Downstream not ready for 3 cycles with requesters 0 and 2 eligible.
    ri = 1'b0; req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      vc = {4{pol}};
      #1;
      chk($sformatf("stall_gnt_%0d", c), 64'(gnt), 64'h0);
      tick();
      pol = ~pol;
      chk($sformatf("stall_so_%0d", c), 64'(so), 64'h0);
    end
    chk("stall_cnt", 64'(pkt_count), 64'h5);
    // rr_ptr still 1: scan 1,2 -> requester 2 wins.
    ri = 1'b1; vc = {4{pol}};
    #1;
    chk("resume_gnt", 64'(gnt), 64'h4);
    tick();
    pol = ~pol;
    chk("resume_so",  64'(so),        64'h1);
    chk("resume_do",  do_o,           D2);
    chk("resume_cnt", 64'(pkt_count), 64'h6);

    // Polarity is 1 here; idle one cycle to reach polarity 0.
    req = 4'b0000; tick(); pol = ~pol;
    chk("idle_pol", 64'(polarity), 64'h0);
    // vc=1 request ignored at polarity 0, served at polarity 1.
    req = 4'b0010; vc = 4'b0010;
    #1;
    chk("vcmis_gnt0", 64'(gnt), 64'h0);
    tick(); pol = ~pol;
    chk("vcmis_so0",  64'(so),  64'h0);
    chk("vcmis_gnt1", 64'(gnt), 64'h2);
    tick(); pol = ~pol;
    chk("vcmis_so1",  64'(so),        64'h1);
    chk("vcmis_do1",  do_o,           D1);
    chk("vcmis_cnt",  64'(pkt_count), 64'h7);

    // Enable low blocks grants (polarity 0, rr_ptr=2).
    en = 1'b0; req = 4'b1111; vc = 4'b0000;
    #1;
    chk("en0_gnt", 64'(gnt), 64'h0);
    tick(); pol = ~pol;
    chk("en0_so",  64'(so),        64'h0);
    chk("en0_cnt", 64'(pkt_count), 64'h7);
    // Polarity 1 now; one idle cycle back to 0.
    tick(); pol = ~pol;
    en = 1'b1; vc = 4'b0000;
    #1;
    chk("pre_rst_gnt", 64'(gnt), 64'h4);
    // Reset lands on what would be a grant edge.
    reset = 1'b0;
    #1;
    chk("rst_grant_gnt", 64'(gnt), 64'h0);
    tick();
    chk("rst_grant_so",  64'(so),        64'h0);
    chk("rst_grant_do",  do_o,           64'h0);
    chk("rst_grant_cnt", 64'(pkt_count), 64'h0);
    chk("rst_grant_pol", 64'(polarity),  64'h0);
    reset = 1'b1;
    #1;
    chk("post_rst_gnt", 64'(gnt), 64'h1);

    // Counter wrap: a grant on every cycle for 65535 cycles, then one more.
    pol = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      vc = {4{pol}};
      tick();
      pol = ~pol;
    end
    chk("wrap_ffff", 64'(pkt_count), 64'hFFFF);
    vc = {4{pol}};
    tick();
    chk("wrap_zero", 64'(pkt_count), 64'h0);
    chk("wrap_so",   64'(so),        64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter PACKET_WIDTH, default 64, gives the packet width in bits.
REQ-002 Parameter NREQ, fixed at 4, gives the number of requesters (input ports sharing one router output channel).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  arbitration enable; 0 blocks all grants.
REQ-006 ri  input  1  downstream ready; 1 = downstream buffer can accept a packet this cycle.
REQ-007 req  input  NREQ  per-requester request; bit i = requester i holds a packet.
REQ-008 vc  input  NREQ  per-requester virtual-channel bit of the held packet.
REQ-009 di  input  NREQ*PACKET_WIDTH  packed requester data; requester i occupies bits [PACKET_WIDTH*i +: PACKET_WIDTH].
REQ-010 gnt  output  NREQ  one-hot combinational grant; requester i pops its buffer on the clock edge that ends a cycle with gnt[i]=1.
REQ-011 so  output  1  registered send strobe to downstream.
REQ-012 do  output  PACKET_WIDTH  registered packet data to downstream.
REQ-013 polarity  output  1  registered phase bit, shared with the attached NIC and buffers.
REQ-014 pkt_count  output  16  registered count of packets forwarded.

Function
REQ-015 polarity shall toggle on every rising edge while reset=1.
REQ-016 Requester i shall be eligible in a cycle when req[i]=1 and vc[i]==polarity.
REQ-017 A grant shall occur in a cycle only when en=1, ri=1 and at least one requester is eligible.
REQ-018 The winner shall be the first eligible requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ; rr_ptr is a 2-bit internal register.
REQ-019 gnt shall be combinational from the current req, vc, polarity, en, ri and rr_ptr, shall be one-hot when a grant occurs, and shall be all zeros otherwise.
REQ-020 On a grant edge, so shall become 1, do shall capture the winner's di slice, rr_ptr shall become (winner+1) mod NREQ, and pkt_count shall increment by 1.
REQ-021 On a non-grant edge, so shall become 0, and do, rr_ptr and pkt_count shall hold their values.
REQ-022 Packet latency from a grant cycle to so=1 shall be exactly one cycle.
REQ-023 At most one packet shall be forwarded per cycle.
REQ-024 A single requester with a fixed vc shall be served at most every other cycle because of polarity alternation.
REQ-025 pkt_count shall wrap from 0xFFFF to 0x0000 without a flag.
REQ-026 ri=0 or en=0 shall suppress the grant even when requests are eligible, with no change to rr_ptr.
REQ-027 Requests whose vc does not match polarity shall be ignored in that cycle; they shall not be lost, and they are re-evaluated in the next cycle.
REQ-028 The arbiter shall hold no packet storage beyond the do register; it issues no grant without ri=1.

Reset
REQ-029 When reset=0 on a rising edge: so=0, do=0, polarity=0, rr_ptr=0 and pkt_count=0.
REQ-030 reset=0 shall override every other input on that edge, including an in-progress grant; no packet is captured and no pkt_count increment occurs.
REQ-031 While reset=0, gnt shall be forced to all zeros.
REQ-032 After reset deasserts, the first cycle shall have polarity=0.

Verification
REQ-033 Reset, then req=0001, vc=0000, di0=64'hDEADBEEFDEADBEEF, en=1, ri=1 -> gnt=0001 in polarity-0 cycles only; so=1 and do=DEADBEEFDEADBEEF on the following cycle; pkt_count increments every second cycle.
REQ-034 req=1111, vc tracking polarity each cycle, ri=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; pkt_count=4 after 4 grants.
REQ-035 ri=0 with req=0101 eligible for 3 cycles -> gnt=0000 and so=0 throughout; rr_ptr unchanged; on ri=1, the first grant goes to the requester selected from the unchanged rr_ptr.
REQ-036 req=0010, vc=0010, polarity=0 -> gnt=0000; next cycle (polarity=1) -> gnt=0010, then so=1.
REQ-037 Preload pkt_count to 0xFFFF through 65535 grants, then 1 more grant -> pkt_count=0x0000.
REQ-038 Assert reset=0 in the same cycle as a grant -> next cycle so=0, do=0, pkt_count=0, polarity=0.
